// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use/branch interlocks plus a one-entry scoreboard for the long-latency unit.
// stall/bubble are combinational in the same cycle; scoreboard state and stallCount are registered.
module hazard_scoreboard #(
    parameter int RW       = 5,
    parameter int LAT      = 4,
    parameter int CW       = 16,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ID_valid,
    input  logic [RW-1:0] ID_rs,
    input  logic [RW-1:0] ID_rt,
    input  logic [RW-1:0] ID_rw,
    input  logic          ID_regWrite,
    input  logic          ID_isLong,
    input  logic          ID_uncertainJump,
    input  logic          ID_flush,
    input  logic [RW-1:0] EX_rw,
    input  logic [RW-1:0] MEM_rw,
    input  logic          EX_memToReg,
    input  logic          MEM_memToReg,
    input  logic          EX_regWrite,
    output logic          stall,
    output logic          bubble,
    output logic          longBusy,
    output logic [RW-1:0] longRw,
    output logic [CW-1:0] stallCount
);

    localparam int CNTW = $clog2(LAT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_nxt;
    logic [RW-1:0]   r_long_rw;
    logic [RW-1:0]   w_long_rw_nxt;
    logic [CW-1:0]   r_stall_cnt;
    logic            w_long_busy;
    logic            w_v;
    logic            w_stall;
    logic            w_issue;

    function automatic logic nz(input logic [RW-1:0] r);
        return (r != '0) || (ZERO_REG == 0);
    endfunction

    function automatic logic rd(input logic [RW-1:0] r, input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (r == a) || (r == b);
    endfunction

    assign w_long_busy = (r_cnt != '0);
    assign w_v         = ID_valid && !ID_flush;

    always_comb begin
        w_stall = 1'b0;
        if (w_v) begin
            w_stall = (EX_memToReg && nz(EX_rw) && rd(EX_rw, ID_rs, ID_rt))
                   || (ID_uncertainJump && EX_regWrite && nz(EX_rw) && rd(EX_rw, ID_rs, ID_rt))
                   || (ID_uncertainJump && MEM_memToReg && nz(MEM_rw) && rd(MEM_rw, ID_rs, ID_rt))
                   || (w_long_busy && nz(r_long_rw) && rd(r_long_rw, ID_rs, ID_rt))
                   || (w_long_busy && ID_regWrite && nz(r_long_rw) && (ID_rw == r_long_rw))
                   || (w_long_busy && ID_isLong);
        end
    end

    assign w_issue = w_v && ID_isLong && !w_stall;

    // BUSY never sees an issue: a busy scoreboard always raises the structural stall.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_long_rw_nxt = r_long_rw;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_state_nxt   = BUSY;
                    w_cnt_nxt     = CNTW'(LAT);
                    w_long_rw_nxt = ID_regWrite ? ID_rw : '0;
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNTW'(1);
                end
                if (r_cnt <= CNTW'(1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_long_rw   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_long_rw <= w_long_rw_nxt;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end
        end
    end

    assign stall      = w_stall;
    assign bubble     = w_stall;
    assign longBusy   = w_long_busy;
    assign longRw     = r_long_rw;
    assign stallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (LAT=4, CW=4 so saturation is reachable quickly).
module tb_hazard_scoreboard;

    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ID_valid;
    logic [RW-1:0] ID_rs;
    logic [RW-1:0] ID_rt;
    logic [RW-1:0] ID_rw;
    logic          ID_regWrite;
    logic          ID_isLong;
    logic          ID_uncertainJump;
    logic          ID_flush;
    logic [RW-1:0] EX_rw;
    logic [RW-1:0] MEM_rw;
    logic          EX_memToReg;
    logic          MEM_memToReg;
    logic          EX_regWrite;
    logic          stall;
    logic          bubble;
    logic          longBusy;
    logic [RW-1:0] longRw;
    logic [CW-1:0] stallCount;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.RW(RW), .LAT(4), .CW(CW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rw(ID_rw),
        .ID_regWrite(ID_regWrite), .ID_isLong(ID_isLong),
        .ID_uncertainJump(ID_uncertainJump), .ID_flush(ID_flush),
        .EX_rw(EX_rw), .MEM_rw(MEM_rw), .EX_memToReg(EX_memToReg),
        .MEM_memToReg(MEM_memToReg), .EX_regWrite(EX_regWrite),
        .stall(stall), .bubble(bubble), .longBusy(longBusy),
        .longRw(longRw), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        ID_valid = 1'b0; ID_rs = '0; ID_rt = '0; ID_rw = '0;
        ID_regWrite = 1'b0; ID_isLong = 1'b0; ID_uncertainJump = 1'b0; ID_flush = 1'b0;
        EX_rw = '0; MEM_rw = '0; EX_memToReg = 1'b0; MEM_memToReg = 1'b0; EX_regWrite = 1'b0;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_long(input logic [RW-1:0] rw);
        set_idle();
        ID_valid = 1'b1; ID_isLong = 1'b1; ID_regWrite = 1'b1; ID_rw = rw; ID_rs = 5'd1; ID_rt = 5'd2;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        #1;
        checks++; if (longBusy !== 1'b0) begin errors++; $display("FAIL reset_longBusy got %b want 0", longBusy); end
        checks++; if (longRw !== 5'd0) begin errors++; $display("FAIL reset_longRw got %0d want 0", longRw); end
        checks++; if (stallCount !== 4'd0) begin errors++; $display("FAIL reset_stallCount got %0d want 0", stallCount); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        ID_valid = 1'b1; EX_memToReg = 1'b1; EX_rw = 5'd3; ID_rs = 5'd3; ID_rt = 5'd4;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b want 1", stall); end
        checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL load_use_bubble got %b want 1", bubble); end
        next_cycle();
        EX_rw = 5'd0; ID_rs = 5'd0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_r0 got %b want 0", stall); end
        checks++; if (stallCount !== 4'd1) begin errors++; $display("FAIL load_use_count got %0d want 1", stallCount); end
        EX_rw = 5'd4; ID_rs = 5'd0; ID_valid = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_novalid got %b want 0", stall); end
        next_cycle();
    endtask

    task automatic test_branch();
        do_reset();
        ID_valid = 1'b1; ID_uncertainJump = 1'b1; EX_regWrite = 1'b1; EX_rw = 5'd7; ID_rs = 5'd1; ID_rt = 5'd7;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_ex_alu got %b want 1", stall); end
        next_cycle();
        EX_regWrite = 1'b0; EX_rw = 5'd0; MEM_rw = 5'd7; MEM_memToReg = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_mem_alu got %b want 0", stall); end
        MEM_memToReg = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_mem_load got %b want 1", stall); end
        ID_uncertainJump = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nobr_mem_load got %b want 0", stall); end
        next_cycle();
    endtask

    task automatic test_long_raw();
        do_reset();
        set_long(5'd9);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got %b want 0", stall); end
        next_cycle();
        set_idle();
        ID_valid = 1'b1; ID_rs = 5'd9; ID_rt = 5'd2; ID_rw = 5'd10; ID_regWrite = 1'b1;
        checks++; if (longRw !== 5'd9) begin errors++; $display("FAIL raw_longRw got %0d want 9", longRw); end
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (stall !== 1'b1 || longBusy !== 1'b1) begin
                errors++; $display("FAIL raw_t%0d stall/busy got %b/%b want 1/1", i, stall, longBusy);
            end
            next_cycle();
        end
        checks++; if (stall !== 1'b0 || longBusy !== 1'b0) begin
            errors++; $display("FAIL raw_t5 stall/busy got %b/%b want 0/0", stall, longBusy);
        end
        checks++; if (stallCount !== 4'd4) begin errors++; $display("FAIL raw_count got %0d want 4", stallCount); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_long(5'd9);
        next_cycle();
        set_long(5'd11);
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL struct_t%0d got %b want 1", i, stall); end
            next_cycle();
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL struct_issue got %b want 0", stall); end
        next_cycle();
        set_idle();
        #1;
        checks++; if (longBusy !== 1'b1 || longRw !== 5'd11) begin
            errors++; $display("FAIL b2b_second busy/rw got %b/%0d want 1/11", longBusy, longRw);
        end
        for (int i = 0; i < 3; i++) next_cycle();
        checks++; if (longBusy !== 1'b1) begin errors++; $display("FAIL b2b_t9 got %b want 1", longBusy); end
        next_cycle();
        checks++; if (longBusy !== 1'b0) begin errors++; $display("FAIL b2b_t10 got %b want 0", longBusy); end
    endtask

    task automatic test_waw();
        do_reset();
        set_long(5'd9);
        next_cycle();
        set_idle();
        ID_valid = 1'b1; ID_rs = 5'd2; ID_rt = 5'd4; ID_rw = 5'd9; ID_regWrite = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_nowrite got %b want 0", stall); end
        ID_rw = 5'd3; ID_regWrite = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unrelated_alu got %b want 0", stall); end
        next_cycle();
        ID_rw = 5'd9;
        for (int i = 2; i <= 4; i++) begin
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_t%0d got %b want 1", i, stall); end
            next_cycle();
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_t5 got %b want 0", stall); end
        next_cycle();
    endtask

    task automatic test_flush();
        do_reset();
        set_long(5'd9);
        next_cycle();
        set_idle();
        ID_valid = 1'b1; ID_flush = 1'b1; ID_rs = 5'd9;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
        for (int i = 0; i < 3; i++) next_cycle();
        checks++; if (longBusy !== 1'b1) begin errors++; $display("FAIL flush_t4_busy got %b want 1", longBusy); end
        next_cycle();
        checks++; if (longBusy !== 1'b0) begin errors++; $display("FAIL flush_t5_busy got %b want 0", longBusy); end
        checks++; if (stallCount !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", stallCount); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_long(5'd9);
        next_cycle();
        set_idle();
        ID_valid = 1'b1; ID_rs = 5'd9;
        next_cycle();
        rst = 1'b1;
        #1;
        checks++; if (longBusy !== 1'b0 || stallCount !== 4'd0) begin
            errors++; $display("FAIL rst_mid busy/count got %b/%0d want 0/0", longBusy, stallCount);
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b want 0", stall); end
        rst = 1'b0;
        set_idle();
        next_cycle();
        checks++; if (longBusy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got %b want 0", longBusy); end
    endtask

    task automatic test_saturation();
        do_reset();
        ID_valid = 1'b1; EX_memToReg = 1'b1; EX_rw = 5'd5; ID_rt = 5'd5;
        for (int i = 0; i < 14; i++) next_cycle();
        checks++; if (stallCount !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", stallCount); end
        for (int i = 14; i < 20; i++) next_cycle();
        checks++; if (stallCount !== 4'd15) begin errors++; $display("FAIL sat_20 got %0d want 15", stallCount); end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_long_raw();
        test_back_to_back();
        test_waw();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order pipeline, placed in the ID stage. It extends load-use and branch-operand hazard detection with a scoreboard for one long-latency execution unit (multiply/divide), and adds WAW and structural-hazard interlocks. It also drives a pipeline bubble and a saturating stall-cycle performance counter. It produces the stall that freezes PC and IF/ID, and the bubble that is injected into ID/EX.

## Interface
- `RW`, default 5: register-index width.
- `LAT`, default 4: long-latency unit latency in cycles, ≥1.
- `CW`, default 16: stall-counter width.
- `ZERO_REG`, default 1: when 1, register 0 never causes a hazard on any path.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ID_valid` in 1: an instruction is present in ID.
- `ID_rs`, `ID_rt` in RW: source registers read in ID.
- `ID_rw` in RW: destination register of the ID instruction.
- `ID_regWrite` in 1: the ID instruction writes `ID_rw`.
- `ID_isLong` in 1: the ID instruction issues to the long-latency unit.
- `ID_uncertainJump` in 1: conditional branch resolved in ID; it needs its operands in ID.
- `ID_flush` in 1: the ID instruction is being squashed this cycle.
- `EX_rw`, `MEM_rw` in RW: destinations in EX and MEM.
- `EX_memToReg`, `MEM_memToReg` in 1: the EX/MEM instruction is a load.
- `EX_regWrite` in 1: the EX instruction writes `EX_rw`.
- `stall` out 1: hold PC and IF/ID (combinational).
- `bubble` out 1: insert a NOP into ID/EX (combinational, equal to `stall`).
- `longBusy` out 1: the scoreboard holds an outstanding long-latency write (registered).
- `longRw` out RW: destination of the outstanding long op (registered).
- `stallCount` out CW: saturating count of stalled cycles (registered).

## Operation
- `nz(r)`: true when `r != 0`, or when `ZERO_REG == 0`.
- `rd(r)`: true when `r == ID_rs` or `r == ID_rt`.
- `v`: `ID_valid && !ID_flush`. All hazard terms are gated by `v`.
- LOAD: `EX_memToReg && nz(EX_rw) && rd(EX_rw)`.
- BR_EX: `ID_uncertainJump && EX_regWrite && nz(EX_rw) && rd(EX_rw)`. This covers ALU results as well as loads, because the branch compares in ID.
- BR_MEM: `ID_uncertainJump && MEM_memToReg && nz(MEM_rw) && rd(MEM_rw)`.
- SB_RAW: `longBusy && nz(longRw) && rd(longRw)`.
- SB_WAW: `longBusy && ID_regWrite && nz(longRw) && ID_rw == longRw`.
- SB_STRUCT: `longBusy && ID_isLong`.
- `stall` is the OR of all six terms. `bubble` equals `stall`.
- Issue: `v && ID_isLong && !stall`.
- Scoreboard FSM, states IDLE and BUSY:
  - IDLE to BUSY on issue: load `cnt` with `LAT` and latch `longRw` from `ID_rw` (0 if `!ID_regWrite`).
  - BUSY: decrement `cnt` each cycle. The transition from 1 to 0 returns to IDLE.
  - BUSY never accepts a new issue, because SB_STRUCT forces `stall`.
  - `cnt` is `$clog2(LAT+1)` bits wide and never wraps below 0.
- `longBusy` is `cnt != 0`.
- `ID_flush` never cancels an op that has already issued. It only suppresses hazards for the squashed ID instruction.
- `stallCount` increments on each cycle with `stall == 1` and saturates at all-ones.

## Timing
- `stall` and `bubble` are combinational from the inputs and registered state, valid in the same cycle.
- On reset (asynchronous, immediate): `cnt` = 0, `longBusy` = 0, `longRw` = 0, `stallCount` = 0. Outputs `stall`/`bubble` then follow the inputs alone.
- A long op issued in ID at cycle t gives `longBusy` = 1 during cycles t+1 through t+LAT, and 0 at t+LAT+1.
- A dependent instruction in ID at t+1 stalls for LAT cycles and issues at t+LAT+1.
- Back-to-back long ops: the second one issues at t+LAT+1.
- Simultaneous events: a release (`cnt` going 1 to 0) and a new issue in the same cycle cannot occur, because `longBusy` = 1 during that cycle stalls the issue. The next issue happens one cycle later.
- `rst` asserted mid-BUSY abandons the scoreboard entry immediately, and the next cycle is IDLE.

## Test plan
- Load-use: `EX_memToReg`=1, `EX_rw`=3, `ID_rs`=3 → `stall`=1 for that cycle. With `EX_rw`=0 and `ZERO_REG`=1 → `stall`=0.
- Branch on ALU result: `ID_uncertainJump`=1, `EX_regWrite`=1, `EX_rw`=7, `ID_rt`=7 → `stall`=1. Next cycle, the same register in MEM as a non-load → `stall`=0.
- Long RAW with `LAT`=4: issue with `ID_rw`=9 at t, consumer reading 9 in ID from t+1 → `stall`=1 for t+1 to t+4, `stall`=0 and issue at t+5. `stallCount` = 4.
- Structural and WAW: a second long op at t+1, or a write to reg 9 at t+2 → stalled until `longBusy` falls. An unrelated ALU op reading reg 2 → no stall.
- Flush and reset: `ID_flush`=1 while a RAW hazard is present → `stall`=0, and `longBusy` keeps counting. `rst` pulsed at t+2 of an op → `longBusy`=0 and `stallCount`=0 immediately.
- Saturation: with `CW`=4, hold a hazard for 20 cycles → `stallCount` stops at 15.
